// File: rtl/mtl_pkg.sv
// rtl/mtl_pkg.sv - shared types and frame geometry for the MTL pixel prefetcher
package mtl_pkg;

    localparam int H_ACTIVE         = 800;
    localparam int V_ACTIVE         = 480;
    localparam int PIXELS_PER_FRAME = H_ACTIVE * V_ACTIVE;

    typedef logic [31:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        DATA,
        FLUSH,
        DONE
    } prefetch_state_t;

endpackage

// File: rtl/mtl_pixel_fifo.sv
// rtl/mtl_pixel_fifo.sv - pixel FIFO with synchronous clear and registered read port
module mtl_pixel_fifo
    import mtl_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             clr,
    input  logic             wr_en,
    input  pixel_t           wr_data,
    input  logic             rd_en,
    output pixel_t           rd_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    pixel_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign do_wr = wr_en && !clr;
    assign do_rd = rd_en && !clr && !empty;

    always_ff @(posedge iCLK) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // A clear drops all content; a read colliding with it returns zero rather than stale data.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            if (rd_en) begin
                rd_data <= '0;
            end
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_data <= empty ? '0 : mem[rd_ptr];
            end
            if (do_wr && !do_rd) begin
                count <= count + CNT_W'(1);
            end else if (!do_wr && do_rd) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    a_no_overflow: assert property (@(posedge iCLK) disable iff (iRST) !(do_wr && full && !do_rd));

endmodule

// File: rtl/mtl_pixel_prefetch.sv
// rtl/mtl_pixel_prefetch.sv - SDRAM burst prefetcher feeding the MTL LCD pixel stream
module mtl_pixel_prefetch #(
    parameter int PIXELS_PER_FRAME = mtl_pkg::PIXELS_PER_FRAME,
    parameter int BURST_LEN        = 16,
    parameter int FIFO_DEPTH       = 64,
    parameter int ADDR_W           = 24
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iNewFrame,
    input  logic [ADDR_W-1:0] iFrameBase,
    input  logic              iREAD_EN,
    output logic [31:0]       oREAD_DATA,
    output logic              oRD_REQ,
    output logic [ADDR_W-1:0] oRD_ADDR,
    output logic [4:0]        oRD_LEN,
    input  logic              iRD_ACK,
    input  logic              iRD_VALID,
    input  logic [31:0]       iRD_DATA,
    output logic              oUNDERFLOW
);

    import mtl_pkg::*;

    localparam int                 REM_W     = $clog2(PIXELS_PER_FRAME + 1);
    localparam int                 CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [REM_W-1:0]   FRAME_REM = REM_W'(PIXELS_PER_FRAME);
    localparam logic [REM_W-1:0]   BURST_REM = REM_W'(BURST_LEN);
    localparam logic [4:0]         FIRST_LEN = 5'((PIXELS_PER_FRAME < BURST_LEN) ? PIXELS_PER_FRAME : BURST_LEN);
    localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    prefetch_state_t   state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pbase_q, pbase_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [4:0]        len_q, len_d;
    logic [4:0]        beats_q, beats_d;
    logic              pend_q, pend_d;
    logic              underflow_q;

    logic              fifo_wr;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [4:0]        nxt_len;
    logic              space_ok;
    logic              restart;
    logic [ADDR_W-1:0] restart_base;

    mtl_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .clr     (iNewFrame),
        .wr_en   (fifo_wr),
        .wr_data (iRD_DATA),
        .rd_en   (iREAD_EN),
        .rd_data (oREAD_DATA),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    // Only request when the whole burst already has room, so the FIFO cannot overflow.
    assign nxt_len  = (rem_q >= BURST_REM) ? 5'(BURST_LEN) : 5'(rem_q);
    assign space_ok = (DEPTH_CNT - fifo_count) >= CNT_W'(nxt_len);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pbase_q <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            beats_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pbase_q <= pbase_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            beats_q <= beats_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pbase_d      = pbase_q;
        rem_d        = rem_q;
        len_d        = len_q;
        beats_d      = beats_q;
        pend_d       = pend_q;
        fifo_wr      = 1'b0;
        restart      = 1'b0;
        restart_base = iFrameBase;
        case (state_q)
            IDLE, DONE: restart = iNewFrame;
            REQ: begin
                // The request is never withdrawn; a frame pulse here turns the acked burst into a flush.
                if (iNewFrame) begin
                    pend_d  = 1'b1;
                    pbase_d = iFrameBase;
                end
                if (iRD_ACK) begin
                    addr_d  = addr_q + ADDR_W'(len_q);
                    rem_d   = rem_q - REM_W'(len_q);
                    beats_d = len_q;
                    pend_d  = 1'b0;
                    state_d = (pend_q || iNewFrame) ? FLUSH : DATA;
                end
            end
            DATA: begin
                if (beats_q != '0) begin
                    fifo_wr = iRD_VALID;
                    if (iRD_VALID) begin
                        beats_d = beats_q - 5'd1;
                    end
                    if (iNewFrame) begin
                        pbase_d = iFrameBase;
                        if (beats_d == '0) begin
                            restart = 1'b1;
                        end else begin
                            state_d = FLUSH;
                        end
                    end
                end else if (iNewFrame) begin
                    restart = 1'b1;
                end else if (rem_q == '0) begin
                    state_d = DONE;
                end else if (space_ok) begin
                    state_d = REQ;
                    len_d   = nxt_len;
                end
            end
            FLUSH: begin
                if (iNewFrame) begin
                    pbase_d = iFrameBase;
                end
                if (iRD_VALID) begin
                    beats_d = beats_q - 5'd1;
                    if (beats_q == 5'd1) begin
                        restart      = 1'b1;
                        restart_base = iNewFrame ? iFrameBase : pbase_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (restart) begin
            state_d = REQ;
            addr_d  = restart_base;
            rem_d   = FRAME_REM;
            len_d   = FIRST_LEN;
            beats_d = '0;
            pend_d  = 1'b0;
        end
    end

    // A frame pulse always clears the flag, even when it coincides with a read of an empty FIFO.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            underflow_q <= 1'b0;
        end else if (iNewFrame) begin
            underflow_q <= 1'b0;
        end else if (iREAD_EN && fifo_empty) begin
            underflow_q <= 1'b1;
        end
    end

    assign oRD_REQ    = (state_q == REQ);
    assign oRD_ADDR   = addr_q;
    assign oRD_LEN    = len_q;
    assign oUNDERFLOW = underflow_q;

endmodule

// File: tb/tb_mtl_pixel_prefetch.sv
// tb/tb_mtl_pixel_prefetch.sv - directed self-checking bench for mtl_pixel_prefetch
module tb_mtl_pixel_prefetch;

    localparam int ADDR_W = 24;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              new_frame = 1'b0;
    logic [ADDR_W-1:0] frame_base = '0;
    logic              read_en = 1'b0;
    logic [31:0]       read_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [4:0]        rd_len;
    logic              rd_ack = 1'b0;
    logic              rd_valid = 1'b0;
    logic [31:0]       rd_data = '0;
    logic              underflow;

    int vectors = 0;
    int miscompares = 0;
    int mark = 0;

    int                ack_stall = 0;
    int                wait_cnt = 0;
    int                beats_left = 0;
    int                beat_idx = 0;
    logic [ADDR_W-1:0] cur_addr = '0;
    logic [ADDR_W-1:0] req_addr [$];
    int                req_len [$];

    always #5 clk = ~clk;

    mtl_pixel_prefetch #(
        .PIXELS_PER_FRAME (40),
        .BURST_LEN        (16),
        .FIFO_DEPTH       (64),
        .ADDR_W           (ADDR_W)
    ) dut (
        .iCLK       (clk),
        .iRST       (rst),
        .iNewFrame  (new_frame),
        .iFrameBase (frame_base),
        .iREAD_EN   (read_en),
        .oREAD_DATA (read_data),
        .oRD_REQ    (rd_req),
        .oRD_ADDR   (rd_addr),
        .oRD_LEN    (rd_len),
        .iRD_ACK    (rd_ack),
        .iRD_VALID  (rd_valid),
        .iRD_DATA   (rd_data),
        .oUNDERFLOW (underflow)
    );

    // SDRAM model: acks after ack_stall request cycles, then returns an address-ramp burst.
    initial begin
        forever begin
            @(negedge clk);
            rd_ack   = 1'b0;
            rd_valid = 1'b0;
            if (rst) begin
                beats_left = 0;
                wait_cnt   = 0;
                beat_idx   = 0;
            end else if (beats_left > 0) begin
                rd_valid   = 1'b1;
                rd_data    = {8'h00, cur_addr};
                cur_addr   = cur_addr + 1'b1;
                beats_left = beats_left - 1;
                beat_idx   = beat_idx + 1;
            end else if (rd_req) begin
                if (wait_cnt >= ack_stall) begin
                    rd_ack     = 1'b1;
                    req_addr.push_back(rd_addr);
                    req_len.push_back(int'(rd_len));
                    cur_addr   = rd_addr;
                    beats_left = int'(rd_len);
                    beat_idx   = 0;
                    wait_cnt   = 0;
                end else begin
                    wait_cnt = wait_cnt + 1;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) step();
        vectors++; if (read_data !== 32'h0) begin miscompares++; $display("FAIL reset_read_data got %h want %h", read_data, 32'h0); end
        vectors++; if (rd_req !== 1'b0) begin miscompares++; $display("FAIL reset_rd_req got %b want 0", rd_req); end
        vectors++; if (rd_addr !== 24'h0) begin miscompares++; $display("FAIL reset_rd_addr got %h want 000000", rd_addr); end
        vectors++; if (rd_len !== 5'd0) begin miscompares++; $display("FAIL reset_rd_len got %0d want 0", rd_len); end
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL reset_underflow got %b want 0", underflow); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_first_bursts();
        logic [ADDR_W-1:0] ea [3] = '{24'h000100, 24'h000110, 24'h000120};
        int                el [3] = '{16, 16, 8};
        mark = req_addr.size();
        frame_base = 24'h000100; new_frame = 1'b1; step(); new_frame = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (req_addr.size() >= mark + 3) break;
            step();
        end
        repeat (60) step();
        vectors++; if (req_addr.size() !== mark + 3) begin miscompares++; $display("FAIL burst_count got %0d want %0d", req_addr.size() - mark, 3); end
        for (int k = 0; k < 3; k++) begin
            if (req_addr.size() > mark + k) begin
                vectors++; if (req_addr[mark+k] !== ea[k]) begin miscompares++; $display("FAIL burst%0d_addr got %h want %h", k, req_addr[mark+k], ea[k]); end
                vectors++; if (req_len[mark+k] !== el[k]) begin miscompares++; $display("FAIL burst%0d_len got %0d want %0d", k, req_len[mark+k], el[k]); end
            end
        end
        vectors++; if (rd_req !== 1'b0) begin miscompares++; $display("FAIL done_rd_req got %b want 0", rd_req); end
    endtask

    task automatic test_read_stream();
        for (int i = 0; i < 40; i++) begin
            read_en = 1'b1; step(); read_en = 1'b0;
            vectors++; if (read_data !== 32'h100 + i) begin miscompares++; $display("FAIL stream_word%0d got %h want %h", i, read_data, 32'h100 + i); end
        end
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL stream_underflow got %b want 0", underflow); end
    endtask

    task automatic test_underflow();
        mark = req_addr.size();
        ack_stall = 20;
        frame_base = 24'h000200; new_frame = 1'b1; read_en = 1'b1; step(); new_frame = 1'b0;
        vectors++; if (read_data !== 32'h0) begin miscompares++; $display("FAIL flush_read_data got %h want 0", read_data); end
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL flush_read_underflow got %b want 0", underflow); end
        repeat (3) step();
        read_en = 1'b0;
        vectors++; if (read_data !== 32'h0) begin miscompares++; $display("FAIL empty_read_data got %h want 0", read_data); end
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL empty_underflow got %b want 1", underflow); end
        vectors++; if (rd_req !== 1'b1) begin miscompares++; $display("FAIL stall_rd_req got %b want 1", rd_req); end
        vectors++; if (rd_addr !== 24'h000200) begin miscompares++; $display("FAIL stall_rd_addr got %h want 000200", rd_addr); end
        ack_stall = 0;
        frame_base = 24'h000300; new_frame = 1'b1; step(); new_frame = 1'b0;
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL newframe_clears_underflow got %b want 0", underflow); end
    endtask

    task automatic test_flush_in_req();
        for (int n = 0; n < 200; n++) begin
            if (req_addr.size() >= mark + 2) break;
            step();
        end
        vectors++; if (req_addr.size() < mark + 2) begin miscompares++; $display("FAIL req_flush_requests got %0d want 2", req_addr.size() - mark); end
        if (req_addr.size() >= mark + 2) begin
            vectors++; if (req_addr[mark] !== 24'h000200) begin miscompares++; $display("FAIL req_flush_old_addr got %h want 000200", req_addr[mark]); end
            vectors++; if (req_addr[mark+1] !== 24'h000300) begin miscompares++; $display("FAIL req_flush_new_addr got %h want 000300", req_addr[mark+1]); end
        end
        repeat (80) step();
        read_en = 1'b1; step(); read_en = 1'b0;
        vectors++; if (read_data !== 32'h300) begin miscompares++; $display("FAIL req_flush_first_word got %h want 00000300", read_data); end
    endtask

    task automatic test_flush_in_data();
        logic [ADDR_W-1:0] ea [4] = '{24'h000400, 24'h000500, 24'h000510, 24'h000520};
        int                el [4] = '{16, 16, 16, 8};
        mark = req_addr.size();
        frame_base = 24'h000400; new_frame = 1'b1; step(); new_frame = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (rd_valid && beat_idx == 5) break;
            step();
        end
        vectors++; if (beat_idx !== 5) begin miscompares++; $display("FAIL data_beat5_reached got %0d want 5", beat_idx); end
        frame_base = 24'h000500; new_frame = 1'b1; step(); new_frame = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (req_addr.size() >= mark + 4) break;
            step();
        end
        repeat (60) step();
        vectors++; if (req_addr.size() !== mark + 4) begin miscompares++; $display("FAIL data_flush_requests got %0d want 4", req_addr.size() - mark); end
        for (int k = 0; k < 4; k++) begin
            if (req_addr.size() > mark + k) begin
                vectors++; if (req_addr[mark+k] !== ea[k]) begin miscompares++; $display("FAIL data_flush_req%0d_addr got %h want %h", k, req_addr[mark+k], ea[k]); end
                vectors++; if (req_len[mark+k] !== el[k]) begin miscompares++; $display("FAIL data_flush_req%0d_len got %0d want %0d", k, req_len[mark+k], el[k]); end
            end
        end
        for (int i = 0; i < 40; i++) begin
            read_en = 1'b1; step(); read_en = 1'b0;
            vectors++; if (read_data !== 32'h500 + i) begin miscompares++; $display("FAIL data_flush_word%0d got %h want %h", i, read_data, 32'h500 + i); end
        end
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL data_flush_underflow got %b want 0", underflow); end
        read_en = 1'b1; step(); read_en = 1'b0;
        vectors++; if (read_data !== 32'h0) begin miscompares++; $display("FAIL frame_end_read got %h want 0", read_data); end
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL frame_end_underflow got %b want 1", underflow); end
    endtask

    task automatic test_reset_mid_burst();
        frame_base = 24'h000600; new_frame = 1'b1; step(); new_frame = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (rd_valid && beat_idx == 3) break;
            step();
        end
        read_en = 1'b1; step(); read_en = 1'b0;
        vectors++; if (read_data !== 32'h600) begin miscompares++; $display("FAIL pre_reset_word got %h want 00000600", read_data); end
        mark = req_addr.size();
        rst = 1'b1; step();
        vectors++; if (read_data !== 32'h0) begin miscompares++; $display("FAIL midreset_read_data got %h want 0", read_data); end
        vectors++; if (rd_req !== 1'b0) begin miscompares++; $display("FAIL midreset_rd_req got %b want 0", rd_req); end
        vectors++; if (rd_addr !== 24'h0) begin miscompares++; $display("FAIL midreset_rd_addr got %h want 000000", rd_addr); end
        vectors++; if (rd_len !== 5'd0) begin miscompares++; $display("FAIL midreset_rd_len got %0d want 0", rd_len); end
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL midreset_underflow got %b want 0", underflow); end
        rst = 1'b0;
        repeat (10) step();
        vectors++; if (rd_req !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle got %b want 0", rd_req); end
        vectors++; if (req_addr.size() !== mark) begin miscompares++; $display("FAIL post_reset_requests got %0d want 0", req_addr.size() - mark); end
        read_en = 1'b1; step(); read_en = 1'b0;
        vectors++; if (read_data !== 32'h0) begin miscompares++; $display("FAIL post_reset_read got %h want 0", read_data); end
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL post_reset_underflow got %b want 1", underflow); end
    endtask

    initial begin
        test_reset();
        test_first_bursts();
        test_read_stream();
        test_underflow();
        test_flush_in_req();
        test_flush_in_data();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
